// File: rtl/vsynth_pkg.sv
// Shared MIDI constants, parser state type and status-byte helpers for the
// voice synthesiser blocks.
package vsynth_pkg;

  localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
  localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
  localparam logic [3:0] MIDI_CC       = 4'hB;
  localparam logic [3:0] MIDI_PROG     = 4'hC;
  localparam logic [3:0] MIDI_CHPRESS  = 4'hD;

  localparam logic [6:0] CC_ALL_SOUND_OFF = 7'd120;
  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

  typedef enum logic [1:0] {
    IDLE,
    D1,
    D2
  } parser_state_t;

  // Program Change and Channel Pressure carry a single data byte.
  function automatic logic is_one_byte(input logic [3:0] kind);
    return (kind == MIDI_PROG) || (kind == MIDI_CHPRESS);
  endfunction

endpackage

// File: rtl/voice_lru.sv
// LRU age tracker: ages stay a permutation of 0..VOICES-1, age 0 is the most
// recently touched voice and age VOICES-1 the steal candidate.
module voice_lru #(
  parameter int VOICES = 4,
  parameter int AGE_W  = $clog2(VOICES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    touch,
  input  logic [AGE_W-1:0]        touch_idx,
  output logic [AGE_W-1:0]        oldest_idx,
  output logic [AGE_W*VOICES-1:0] ages
);

  logic [AGE_W-1:0] age_q [VOICES];
  logic [AGE_W-1:0] touched_age;

  assign touched_age = age_q[touch_idx];

  // Every voice younger than the touched one ages by one; the touched voice
  // becomes the newest, which keeps the permutation intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < VOICES; i++) age_q[i] <= AGE_W'(i);
    end else if (touch) begin
      for (int i = 0; i < VOICES; i++) begin
        if (AGE_W'(i) == touch_idx)
          age_q[i] <= '0;
        else if (age_q[i] < touched_age)
          age_q[i] <= age_q[i] + AGE_W'(1);
      end
    end
  end

  always_comb begin
    oldest_idx = '0;
    ages       = '0;
    for (int i = 0; i < VOICES; i++) begin
      ages[AGE_W*i +: AGE_W] = age_q[i];
      if (age_q[i] == AGE_W'(VOICES - 1)) oldest_idx = AGE_W'(i);
    end
  end

endmodule

// File: rtl/poly_voice_alloc.sv
// MIDI byte-stream parser with running status and polyphonic voice allocation
// (retrigger, lowest free voice, LRU steal) for one selectable channel.
module poly_voice_alloc #(
  parameter int VOICES = 4,
  parameter int AGE_W  = $clog2(VOICES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [3:0]            channel,
  input  logic [7:0]            data,
  input  logic                  dv,
  output logic [6:0]            program_num,
  output logic [7*VOICES-1:0]   note_num,
  output logic [7*VOICES-1:0]   note_vel,
  output logic [VOICES-1:0]     voice_active
);

  import vsynth_pkg::*;

  parser_state_t state, state_n;
  logic [3:0]    kind_q;
  logic          match_q;
  logic [6:0]    byte1_q;

  logic accept, is_status, is_common, is_data, complete, exec;
  logic [6:0] arg1, arg2;

  assign accept    = ce && dv;
  assign is_status = data[7] && (data[7:4] != 4'hF);
  assign is_common = (data[7:3] == 5'b11110);
  assign is_data   = !data[7];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Realtime bytes fall through every branch, so they never disturb framing.
  always_comb begin
    state_n  = state;
    complete = 1'b0;
    if (accept) begin
      if (is_status) begin
        state_n = D1;
      end else if (is_common) begin
        state_n = IDLE;
      end else if (is_data) begin
        case (state)
          D1: begin
            if (is_one_byte(kind_q)) complete = 1'b1;
            else                     state_n  = D2;
          end
          D2: begin
            complete = 1'b1;
            state_n  = D1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kind_q  <= '0;
      match_q <= 1'b0;
      byte1_q <= '0;
    end else begin
      if (accept && is_status) begin
        kind_q  <= data[7:4];
        match_q <= (data[3:0] == channel);
      end
      if (accept && is_data && (state == D1)) byte1_q <= data[6:0];
    end
  end

  // A one-byte message completes in D1, so its argument is the live byte.
  assign arg1 = (state == D1) ? data[6:0] : byte1_q;
  assign arg2 = data[6:0];
  assign exec = complete && match_q;

  logic note_on_go, note_off_go, all_off_go, prog_go;

  assign note_on_go  = exec && (kind_q == MIDI_NOTE_ON) && (arg2 != 7'd0);
  assign note_off_go = exec && ((kind_q == MIDI_NOTE_OFF) ||
                                ((kind_q == MIDI_NOTE_ON) && (arg2 == 7'd0)));
  assign all_off_go  = exec && (kind_q == MIDI_CC) &&
                       ((arg1 == CC_ALL_SOUND_OFF) || (arg1 == CC_ALL_NOTES_OFF));
  assign prog_go     = exec && (kind_q == MIDI_PROG);

  logic [6:0]        num_q [VOICES];
  logic [6:0]        vel_q [VOICES];
  logic [VOICES-1:0] active_q;
  logic [6:0]        program_q;

  logic [VOICES-1:0] hit;
  logic              hit_any, free_any;
  logic [AGE_W-1:0]  hit_idx, free_idx, oldest_idx, sel;
  logic [AGE_W*VOICES-1:0] lru_ages_unused;

  // Descending scan so the lowest matching / free index wins.
  always_comb begin
    hit      = '0;
    hit_any  = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = VOICES - 1; i >= 0; i--) begin
      hit[i] = active_q[i] && (num_q[i] == arg1);
      if (hit[i]) begin
        hit_any = 1'b1;
        hit_idx = AGE_W'(i);
      end
      if (!active_q[i]) begin
        free_any = 1'b1;
        free_idx = AGE_W'(i);
      end
    end
    sel = hit_any ? hit_idx : (free_any ? free_idx : oldest_idx);
  end

  voice_lru #(
    .VOICES (VOICES),
    .AGE_W  (AGE_W)
  ) u_lru (
    .clk        (clk),
    .rst        (rst),
    .touch      (note_on_go),
    .touch_idx  (sel),
    .oldest_idx (oldest_idx),
    .ages       (lru_ages_unused)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < VOICES; i++) begin
        num_q[i] <= '0;
        vel_q[i] <= '0;
      end
      active_q  <= '0;
      program_q <= '0;
    end else begin
      if (note_on_go) begin
        num_q[sel]    <= arg1;
        vel_q[sel]    <= arg2;
        active_q[sel] <= 1'b1;
      end
      if (note_off_go) begin
        for (int i = 0; i < VOICES; i++) begin
          if (hit[i]) begin
            vel_q[i]    <= '0;
            active_q[i] <= 1'b0;
          end
        end
      end
      if (all_off_go) begin
        for (int i = 0; i < VOICES; i++) vel_q[i] <= '0;
        active_q <= '0;
      end
      if (prog_go) program_q <= arg1;
    end
  end

  always_comb begin
    note_num = '0;
    note_vel = '0;
    for (int i = 0; i < VOICES; i++) begin
      note_num[7*i +: 7] = num_q[i];
      note_vel[7*i +: 7] = vel_q[i];
    end
  end

  assign voice_active = active_q;
  assign program_num  = program_q;

endmodule

// File: tb/tb_poly_voice_alloc.sv
// Self-checking bench for poly_voice_alloc: directed MIDI scenarios plus
// randomized byte streams compared against a message-level reference model.
module tb_poly_voice_alloc;

  localparam int VOICES = 4;

  logic                clk = 1'b0;
  logic                rst, ce, dv;
  logic [3:0]          channel;
  logic [7:0]          data;
  logic [6:0]          program_num;
  logic [7*VOICES-1:0] note_num, note_vel;
  logic [VOICES-1:0]   voice_active;

  int tests_run    = 0;
  int tests_failed = 0;

  poly_voice_alloc #(.VOICES(VOICES)) dut (
    .clk          (clk),
    .rst          (rst),
    .ce           (ce),
    .channel      (channel),
    .data         (data),
    .dv           (dv),
    .program_num  (program_num),
    .note_num     (note_num),
    .note_vel     (note_vel),
    .voice_active (voice_active)
  );

  always #5 clk = ~clk;

  // Reference model: voice table, recency list (front = newest), message framing.
  logic [6:0]        m_num [VOICES];
  logic [6:0]        m_vel [VOICES];
  logic [VOICES-1:0] m_act;
  logic [6:0]        m_prog;
  int                lru[$];
  bit                m_running, m_match;
  logic [3:0]        m_kind;
  int                m_need, m_have;
  logic [6:0]        m_b1;
  logic [7:0]        seq[$];

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < VOICES; i++) begin
      m_num[i] = '0;
      m_vel[i] = '0;
    end
    m_act = '0;
    m_prog = '0;
    lru.delete();
    for (int i = 0; i < VOICES; i++) lru.push_back(i);
    m_running = 0;
    m_match = 0;
    m_kind = '0;
    m_need = 0;
    m_have = 0;
    m_b1 = '0;
  endtask

  task automatic modelTouch(input int v);
    for (int k = 0; k < lru.size(); k++) begin
      if (lru[k] == v) begin
        lru.delete(k);
        break;
      end
    end
    lru.push_front(v);
  endtask

  task automatic modelNoteOff(input logic [6:0] n);
    for (int i = 0; i < VOICES; i++) begin
      if (m_act[i] && m_num[i] == n) begin
        m_vel[i] = '0;
        m_act[i] = 1'b0;
      end
    end
  endtask

  task automatic modelExec(input logic [6:0] b1, input logic [6:0] b2);
    int v;
    if (!m_match) return;
    case (m_kind)
      4'h9: begin
        if (b2 == 0) modelNoteOff(b1);
        else begin
          v = -1;
          for (int i = 0; i < VOICES; i++)
            if (v < 0 && m_act[i] && m_num[i] == b1) v = i;
          for (int i = 0; i < VOICES; i++)
            if (v < 0 && !m_act[i]) v = i;
          if (v < 0) v = lru[lru.size()-1];
          m_num[v] = b1;
          m_vel[v] = b2;
          m_act[v] = 1'b1;
          modelTouch(v);
        end
      end
      4'h8: modelNoteOff(b1);
      4'hB: begin
        if (b1 == 7'd120 || b1 == 7'd123) begin
          for (int i = 0; i < VOICES; i++) m_vel[i] = '0;
          m_act = '0;
        end
      end
      4'hC: m_prog = b1;
      default: ;
    endcase
  endtask

  task automatic modelByte(input logic [7:0] b);
    if (b >= 8'hF8) return;
    if (b >= 8'hF0) begin
      m_running = 0;
      return;
    end
    if (b[7]) begin
      m_kind = b[7:4];
      m_match = (b[3:0] == channel);
      m_need = (m_kind == 4'hC || m_kind == 4'hD) ? 1 : 2;
      m_have = 0;
      m_running = 1;
      return;
    end
    if (!m_running) return;
    if (m_have == 0) begin
      m_b1 = b[6:0];
      if (m_need == 1) modelExec(m_b1, 7'd0);
      else m_have = 1;
    end else begin
      modelExec(m_b1, b[6:0]);
      m_have = 0;
    end
  endtask

  function automatic logic [63:0] expNum();
    logic [63:0] e = '0;
    for (int i = 0; i < VOICES; i++) e[7*i +: 7] = m_num[i];
    return e;
  endfunction

  function automatic logic [63:0] expVel();
    logic [63:0] e = '0;
    for (int i = 0; i < VOICES; i++) e[7*i +: 7] = m_vel[i];
    return e;
  endfunction

  task automatic applyStimulus(input logic [7:0] b, input bit v, input bit c, input bit r);
    data = b;
    dv = v;
    ce = c;
    rst = r;
    @(posedge clk);
    #1;
    if (r) modelReset();
    else if (c && v) modelByte(b);
    checkOutput("program", 64'(program_num), 64'(m_prog));
    checkOutput("note_num", 64'(note_num), expNum());
    checkOutput("note_vel", 64'(note_vel), expVel());
    checkOutput("voice_active", 64'(voice_active), 64'(m_act));
  endtask

  task automatic sendSeq(input bit c);
    foreach (seq[k]) applyStimulus(seq[k], 1'b1, c, 1'b0);
  endtask

  task automatic doReset();
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  function automatic logic [7:0] randByte();
    int r = $urandom_range(0, 99);
    logic [3:0] kinds [9] = '{4'h8, 4'h9, 4'h9, 4'h9, 4'hB, 4'hC, 4'hD, 4'hA, 4'hE};
    logic [3:0] ch;
    if (r < 15) begin
      ch = ($urandom_range(0, 3) == 0) ? 4'd2 : 4'd1;
      return {kinds[$urandom_range(0, 8)], ch};
    end
    if (r < 18) return 8'(8'hF8 + $urandom_range(0, 7));
    if (r < 20) return 8'(8'hF0 + $urandom_range(0, 7));
    if (r < 25) return ($urandom_range(0, 1) == 0) ? 8'd120 : 8'd123;
    if (r < 35) return 8'h00;
    return 8'($urandom_range(60, 69));
  endfunction

  initial begin
    modelReset();
    channel = 4'd0;
    data = 8'h00;
    dv = 1'b0;
    ce = 1'b1;
    rst = 1'b1;
    doReset();
    checkOutput("reset_active", 64'(voice_active), 64'h0);
    checkOutput("reset_num", 64'(note_num), 64'h0);

    seq = '{8'hC0, 8'h05};
    sendSeq(1'b1);
    checkOutput("prog_c0_05", 64'(program_num), 64'd5);

    seq = '{8'h90, 8'h3C, 8'h40, 8'h3E, 8'h50};
    sendSeq(1'b1);
    checkOutput("rs_active", 64'(voice_active), 64'b0011);
    checkOutput("rs_v1_num", 64'(note_num[13:7]), 64'd62);
    checkOutput("rs_v1_vel", 64'(note_vel[13:7]), 64'd80);
    seq = '{8'h3C, 8'h00};
    sendSeq(1'b1);
    checkOutput("rs_off_active", 64'(voice_active), 64'b0010);
    checkOutput("rs_off_num", 64'(note_num[6:0]), 64'd60);
    checkOutput("rs_off_vel", 64'(note_vel[6:0]), 64'd0);

    doReset();
    seq = '{8'h90, 8'h3C, 8'h40, 8'h3D, 8'h40, 8'h3E, 8'h40, 8'h3F, 8'h40, 8'h40, 8'h40};
    sendSeq(1'b1);
    checkOutput("steal_v0", 64'(note_num[6:0]), 64'd64);
    seq = '{8'h41, 8'h40};
    sendSeq(1'b1);
    checkOutput("steal_v1", 64'(note_num[13:7]), 64'd65);

    doReset();
    seq = '{8'h90, 8'h3C, 8'h40, 8'h90, 8'h3C, 8'h7F};
    sendSeq(1'b1);
    checkOutput("retrig_active", 64'(voice_active), 64'b0001);
    checkOutput("retrig_vel", 64'(note_vel[6:0]), 64'd127);
    seq = '{8'h90, 8'h3D, 8'h40};
    sendSeq(1'b1);
    checkOutput("retrig_next", 64'(note_num[13:7]), 64'd61);

    channel = 4'd2;
    doReset();
    seq = '{8'h91, 8'h3C, 8'h40};
    sendSeq(1'b1);
    checkOutput("filt_other_ch", 64'(voice_active), 64'h0);
    seq = '{8'h92, 8'h3C, 8'hF8, 8'h40};
    sendSeq(1'b1);
    checkOutput("filt_rt_num", 64'(note_num[6:0]), 64'd60);
    checkOutput("filt_rt_vel", 64'(note_vel[6:0]), 64'd64);
    seq = '{8'hB2, 8'h7B, 8'h00};
    sendSeq(1'b1);
    checkOutput("filt_all_off", 64'(voice_active), 64'h0);

    doReset();
    seq = '{8'h92, 8'h3C};
    sendSeq(1'b1);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b1);
    seq = '{8'h40};
    sendSeq(1'b1);
    checkOutput("mid_reset", 64'(voice_active), 64'h0);
    seq = '{8'h92, 8'h3C, 8'h40};
    sendSeq(1'b1);
    seq = '{8'h82, 8'h3C, 8'h00, 8'h92, 8'h3D, 8'h50};
    sendSeq(1'b0);
    checkOutput("ce_freeze", 64'(voice_active), 64'b0001);

    channel = 4'd1;
    doReset();
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(randByte(), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) != 0),
                    ($urandom_range(0, 199) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
